mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported `main_memory` between the I-cache refill path (read-only) and the D-cache refill/write-back path (read/write). It sits between the two cache controllers and `main_memory`. It serializes their requests with round-robin priority and drives the memory's request pulse. It holds address and write data stable for the memory's full multi-cycle access, and returns `ready`/`read_data` to the owning requester as a one-cycle acknowledge.

---
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one main_memory port
// between the I-cache refill path and the D-cache refill/write-back path.
module mem_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ic_req,
  input  logic [31:0]      ic_addr,
  output logic [31:0]      ic_rdata,
  output logic             ic_ack,
  input  logic             dc_req,
  input  logic             dc_we,
  input  logic [31:0]      dc_addr,
  input  logic [31:0]      dc_wdata,
  output logic [31:0]      dc_rdata,
  output logic             dc_ack,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic             busy,
  output logic [CNT_W-1:0] ic_grants,
  output logic [CNT_W-1:0] dc_grants
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t state;
  logic   last_dc;
  logic   own_dc;
  logic   pick_dc;
  logic   dc_wr;
  logic   done;

  // A tie goes to the port that did not win last time.
  assign pick_dc = dc_req & (~ic_req | ~last_dc);
  assign dc_wr   = pick_dc & dc_we;
  assign done    = (state == WAIT) & mem_ready;

  assign ic_ack   = done & ~own_dc;
  assign dc_ack   = done & own_dc;
  assign ic_rdata = mem_rdata;
  assign dc_rdata = mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last_dc   <= 1'b0;
      own_dc    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      busy      <= 1'b0;
      ic_grants <= '0;
      dc_grants <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ic_req | dc_req) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            own_dc    <= pick_dc;
            last_dc   <= pick_dc;
            mem_read  <= ~dc_wr;
            mem_write <= dc_wr;
            if (pick_dc) begin
              mem_addr <= dc_addr & ~32'h3;
              if (~&dc_grants)
                dc_grants <= dc_grants + ONE;
            end else begin
              mem_addr <= ic_addr & ~32'h3;
              if (~&ic_grants)
                ic_grants <= ic_grants + ONE;
            end
            if (dc_wr)
              mem_wdata <= dc_wdata;
          end
        end
        ISSUE: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          if (mem_ready) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a fixed-latency memory model
// and a round-robin reference model driven by random request rounds.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ic_req = 1'b0;
  logic [31:0] ic_addr = '0;
  logic [31:0] ic_rdata;
  logic        ic_ack;
  logic        dc_req = 1'b0;
  logic        dc_we = 1'b0;
  logic [31:0] dc_addr = '0;
  logic [31:0] dc_wdata = '0;
  logic [31:0] dc_rdata;
  logic        dc_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;
  logic [15:0] ic_grants;
  logic [15:0] dc_grants;

  mem_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr),
    .ic_rdata(ic_rdata), .ic_ack(ic_ack),
    .dc_req(dc_req), .dc_we(dc_we),
    .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_ack(dc_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .ic_grants(ic_grants), .dc_grants(dc_grants)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_dc;
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [31:0] preload(logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  // Memory model: pulse seen at a rising edge, ready 5 edges later.
  logic [31:0] store[logic [31:0]];
  int          mcnt = 0;
  bit          m_we;
  bit          m_ok;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] iss_addr;
  bit          iss_we;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mcnt      <= 0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        mem_ready <= 1'b1;
        if (m_we) begin
          store[m_addr] = mem_wdata;
          mem_rdata <= '0;
        end else begin
          mem_rdata <= store.exists(m_addr) ? store[m_addr]
                                            : preload(m_addr);
        end
      end
    end else begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      if (mem_read | mem_write) begin
        mcnt    <= 5;
        m_we    = mem_write;
        m_addr  = mem_addr;
        m_wdata = mem_wdata;
        m_ok    = !(mem_read & mem_write);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && mcnt > 0) begin
      if (mem_read || mem_write || mem_addr != m_addr ||
          (m_we && mem_wdata != m_wdata))
        m_ok = 1'b0;
    end
    if (!reset && mem_ready) begin
      checks++;
      if (!m_ok) begin
        errors++;
        $display("FAIL mem_protocol addr %h: request or operands moved mid-access", m_addr);
      end
      iss_addr = m_addr;
      iss_we   = m_we;
    end
  end

  // Monitor: pops one expected response per acknowledge.
  always @(negedge clk) begin
    if (ic_ack || dc_ack) begin
      exp_t e;
      checks++;
      if (ic_ack && dc_ack) begin
        errors++;
        $display("FAIL ack_both: both acks high at cycle %0d", cyc);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected: ic=%0b dc=%0b at cycle %0d, none required",
                 ic_ack, dc_ack, cyc);
      end else begin
        e = exp_q.pop_front();
        if (dc_ack != e.is_dc || cyc != e.cyc || !busy ||
            iss_addr != e.addr || iss_we != e.we ||
            (!e.we && (e.is_dc ? dc_rdata : ic_rdata) != e.data)) begin
          errors++;
          $display("FAIL ack: got dc=%0b cyc=%0d busy=%0b addr=%h we=%0b data=%h; need dc=%0b cyc=%0d busy=1 addr=%h we=%0b data=%h",
                   dc_ack, cyc, busy, iss_addr, iss_we,
                   dc_ack ? dc_rdata : ic_rdata,
                   e.is_dc, e.cyc, e.addr, e.we, e.data);
        end
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem[logic [31:0]];
  bit          ref_last_i = 1'b1;
  int          ref_ic = 0;
  int          ref_dc = 0;

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : preload(a);
  endfunction

  task automatic model_grant(bit is_dc, bit we, logic [31:0] a,
                             logic [31:0] d, int at);
    exp_t e;
    e.is_dc = is_dc;
    e.we    = we;
    e.addr  = {a[31:2], 2'b00};
    e.cyc   = at;
    e.data  = we ? 32'h0 : ref_rd(e.addr);
    if (we) ref_mem[e.addr] = d;
    if (is_dc) ref_dc = (ref_dc == 16'hFFFF) ? ref_dc : ref_dc + 1;
    else ref_ic = (ref_ic == 16'hFFFF) ? ref_ic : ref_ic + 1;
    ref_last_i = !is_dc;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(string name);
    checks++;
    if ({mem_addr, mem_wdata, mem_read, mem_write, ic_ack, dc_ack,
         busy, ic_grants, dc_grants} != '0) begin
      errors++;
      $display("FAIL %s: addr=%h wdata=%h rd=%0b wr=%0b ia=%0b da=%0b busy=%0b ig=%0d dg=%0d, all required 0",
               name, mem_addr, mem_wdata, mem_read, mem_write, ic_ack,
               dc_ack, busy, ic_grants, dc_grants);
    end
  endtask

  task automatic check_counts(string name);
    checks++;
    if (ic_grants != 16'(ref_ic) || dc_grants != 16'(ref_dc)) begin
      errors++;
      $display("FAIL %s: grants ic=%0d dc=%0d, required ic=%0d dc=%0d",
               name, ic_grants, dc_grants, ref_ic, ref_dc);
    end
  endtask

  // Raise requests at the start of cycle c0 and hold each until acked.
  task automatic run_round(bit use_i, bit use_d, bit we,
                           logic [31:0] ia, logic [31:0] da,
                           logic [31:0] dw, bit scramble);
    int c0, n, seen, k;
    bit ai, ad, d_first;
    c0 = cyc;
    ic_addr = ia; dc_addr = da; dc_wdata = dw; dc_we = we;
    ic_req = use_i; dc_req = use_d;
    n = int'(use_i) + int'(use_d);
    d_first = use_d && (!use_i || ref_last_i);
    if (d_first) begin
      model_grant(1'b1, we, da, dw, c0 + 7);
      if (use_i) model_grant(1'b0, 1'b0, ia, 32'h0, c0 + 15);
    end else if (use_i) begin
      model_grant(1'b0, 1'b0, ia, 32'h0, c0 + 7);
      if (use_d) model_grant(1'b1, we, da, dw, c0 + 15);
    end
    seen = 0;
    k = 0;
    while (seen < n && k < 40) begin
      @(negedge clk);
      ai = ic_ack; ad = dc_ack;
      seen += int'(ai) + int'(ad);
      @(posedge clk); #1;
      k++;
      if (ai) ic_req = 1'b0;
      if (ad) dc_req = 1'b0;
      if (scramble && n == 1 && cyc >= c0 + 2) begin
        ic_addr = $urandom; dc_addr = $urandom; dc_wdata = $urandom;
        if (cyc == c0 + 3) begin
          ic_req = 1'b0; dc_req = 1'b0;
        end
      end
    end
    if (seen < n) begin
      checks++; errors++;
      $display("FAIL round_timeout: %0d acks seen, %0d required", seen, n);
      exp_q.delete();
    end
    ic_req = 1'b0; dc_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    ref_last_i = 1'b1; ref_ic = 0; ref_dc = 0;
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] a;
    int c0;
    do_reset();
    check_zero("reset_defaults");
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;
    check_zero("post_reset_idle");

    ref_mem[32'h10] = 32'hDEADBEEF;
    store[32'h10]   = 32'hDEADBEEF;
    run_round(1, 0, 0, 32'h10, 0, 0, 0);
    check_counts("icache_read_cnt");

    run_round(0, 1, 1, 0, 32'h104, 32'h12345678, 0);
    run_round(0, 1, 0, 0, 32'h104, 32'h0, 0);
    check_counts("dcache_wr_rd_cnt");

    do_reset();
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;
    run_round(1, 1, 0, 32'h20, 32'h24, 0, 0);
    for (int i = 0; i < 3; i++)
      run_round(1, 1, i[0], 32'h40 + 32'(i), 32'h80 + 32'(4 * i),
                $urandom, 0);
    check_counts("fairness_cnt");

    // Reset at cycle 4 of a D-cache read: no ack may follow.
    c0 = cyc;
    dc_addr = 32'h200; dc_we = 1'b0; dc_req = 1'b1;
    while (cyc < c0 + 4) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    ref_last_i = 1'b1; ref_ic = 0; ref_dc = 0;
    check_zero("reset_mid_txn");
    dc_req = 1'b0;
    @(posedge clk); #2 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_zero("reset_mid_quiet");
    run_round(0, 1, 0, 0, 32'h200, 0, 0);
    check_counts("after_reset_cnt");

    for (int i = 0; i < 40; i++) begin
      int mode;
      mode = $urandom_range(0, 2);
      a = 32'($urandom_range(0, 63));
      run_round(mode != 1, mode != 0, 1'($urandom),
                a, 32'($urandom_range(0, 63)), $urandom,
                1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      if (i % 8 == 7) check_counts("random_cnt");
    end
    check_counts("final_cnt");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d responses never acked, 0 required",
               exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
